// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/register-file/scoreboard bus between the pipeline and regfile_wb_arbiter.
// Perf counter signals exist only when RF_ARB_PERF_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int unsigned N    = 64,
  parameter int unsigned R    = 32,
  parameter int unsigned NREQ = 3
);
  localparam int unsigned ASIZE = $clog2(R);

  logic [NREQ-1:0]       wb_req;
  logic [NREQ*ASIZE-1:0] wb_reg_id;
  logic [NREQ*N-1:0]     wb_data;
  logic [NREQ-1:0]       wb_gnt;
  logic                  rf_wr;
  logic [ASIZE-1:0]      rf_reg_id_w;
  logic [N-1:0]          rf_data_in;
  logic                  iss_valid;
  logic [ASIZE-1:0]      iss_reg_id;
  logic [ASIZE-1:0]      rd_id1;
  logic [ASIZE-1:0]      rd_id2;
  logic                  stall;
  logic [R-1:0]          busy_vec;
`ifdef RF_ARB_PERF_EN
  logic [31:0]           perf_conflict_cnt;
  logic [31:0]           perf_stall_cnt;
`endif

  modport slave (
    input  wb_req, wb_reg_id, wb_data, iss_valid, iss_reg_id, rd_id1, rd_id2,
    output wb_gnt, rf_wr, rf_reg_id_w, rf_data_in, stall, busy_vec
`ifdef RF_ARB_PERF_EN
    , output perf_conflict_cnt, perf_stall_cnt
`endif
  );

  modport master (
    output wb_req, wb_reg_id, wb_data, iss_valid, iss_reg_id, rd_id1, rd_id2,
    input  wb_gnt, rf_wr, rf_reg_id_w, rf_data_in, stall, busy_vec
`ifdef RF_ARB_PERF_EN
    , input perf_conflict_cnt, perf_stall_cnt
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port plus a per-register busy scoreboard.
// Optional perf counters (conflict cycles, stall cycles) enabled by defining RF_ARB_PERF_EN.
module regfile_wb_arbiter #(
  parameter int unsigned N    = 64,
  parameter int unsigned R    = 32,
  parameter int unsigned NREQ = 3
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned ASIZE = $clog2(R);
  localparam int unsigned PW    = $clog2(NREQ);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    scan_idx;
  logic             gnt_any;
  logic [NREQ-1:0]  gnt;
  logic [ASIZE-1:0] sel_id;
  logic [N-1:0]     sel_data;
  logic             rf_wr_q;
  logic [ASIZE-1:0] rf_id_q;
  logic [N-1:0]     rf_data_q;
  logic [R-1:0]     busy_q;
  logic [R-1:0]     busy_nxt;

  // Scan requesters starting at the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = rr_ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_any && bus.wb_req[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
      scan_idx = (scan_idx == PW'(NREQ - 1)) ? '0 : scan_idx + PW'(1);
    end
    if (rst) gnt_any = 1'b0;
    gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == gnt_idx) begin
        sel_id   = bus.wb_reg_id[i*ASIZE +: ASIZE];
        sel_data = bus.wb_data[i*N +: N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      rf_wr_q   <= 1'b0;
      rf_id_q   <= '0;
      rf_data_q <= '0;
    end else begin
      rf_wr_q <= gnt_any;
      if (gnt_any) begin
        rf_id_q   <= sel_id;
        rf_data_q <= sel_data;
        rr_ptr    <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      end
    end
  end

  // Clear on commit first, then set on issue, so a newer writer to the same register wins.
  always_comb begin
    busy_nxt = busy_q;
    if (rf_wr_q)       busy_nxt[rf_id_q]        = 1'b0;
    if (bus.iss_valid) busy_nxt[bus.iss_reg_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  assign bus.wb_gnt      = gnt;
  assign bus.rf_wr       = rf_wr_q;
  assign bus.rf_reg_id_w = rf_id_q;
  assign bus.rf_data_in  = rf_data_q;
  assign bus.busy_vec    = busy_q;
  assign bus.stall       = busy_q[bus.rd_id1] | busy_q[bus.rd_id2];

`ifdef RF_ARB_PERF_EN
  logic [31:0] conflict_q;
  logic [31:0] stall_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      if (($countones(bus.wb_req) >= 2) && (conflict_q != '1)) conflict_q <= conflict_q + 32'd1;
      if (bus.stall && (stall_q != '1))                        stall_q    <= stall_q + 32'd1;
    end
  end

  assign bus.perf_conflict_cnt = conflict_q;
  assign bus.perf_stall_cnt    = stall_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: reset, single grant, round robin,
// scoreboard stall, simultaneous set/clear and reset mid-operation.
module tb_regfile_wb_arbiter;
  localparam int unsigned N     = 64;
  localparam int unsigned R     = 32;
  localparam int unsigned NREQ  = 3;
  localparam int unsigned ASIZE = $clog2(R);

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_wb_arbiter_if #(.N(N), .R(R), .NREQ(NREQ)) bus ();

  regfile_wb_arbiter #(.N(N), .R(R), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input int unsigned idx, input logic [ASIZE-1:0] id, input logic [N-1:0] d);
    bus.wb_reg_id[idx*ASIZE +: ASIZE] = id;
    bus.wb_data[idx*N +: N]           = d;
  endtask

  logic [2:0]  rr_exp [4];
  logic [4:0]  rr_id  [4];

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    rr_id[0]  = 5'd10;  rr_id[1]  = 5'd11;  rr_id[2]  = 5'd12;  rr_id[3]  = 5'd10;

    rst = 1'b1;
    bus.wb_req = 3'b111; bus.wb_reg_id = '0; bus.wb_data = '0;
    bus.iss_valid = 1'b0; bus.iss_reg_id = '0; bus.rd_id1 = '0; bus.rd_id2 = '0;

    // Reset held two cycles with all requests asserted
    cyc(); cyc();
    check("rst_gnt",  64'(bus.wb_gnt), 64'd0);
    check("rst_wr",   64'(bus.rf_wr), 64'd0);
    check("rst_busy", 64'(bus.busy_vec), 64'd0);
    rst = 1'b0; bus.wb_req = 3'b000;
    #1 check("idle_gnt", 64'(bus.wb_gnt), 64'd0);
    cyc();

    // Single request from requester 1
    set_wb(1, 5'd5, 64'hAB);
    bus.wb_req = 3'b010;
    #1 check("single_gnt", 64'(bus.wb_gnt), 64'b010);
    cyc();
    bus.wb_req = 3'b000;
    check("single_wr",   64'(bus.rf_wr), 64'd1);
    check("single_id",   64'(bus.rf_reg_id_w), 64'd5);
    check("single_data", bus.rf_data_in, 64'hAB);
    cyc();
    check("single_wr_off", 64'(bus.rf_wr), 64'd0);
    check("single_id_hold", 64'(bus.rf_reg_id_w), 64'd5);
    check("single_busy", 64'(bus.busy_vec), 64'd0);

    // Move pointer back to 0 via requester 2, then round robin over all three
    set_wb(0, 5'd10, 64'h100);
    set_wb(1, 5'd11, 64'h101);
    set_wb(2, 5'd12, 64'h102);
    bus.wb_req = 3'b100;
    #1 check("ptr_gnt", 64'(bus.wb_gnt), 64'b100);
    cyc();
    bus.wb_req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("rr_gnt%0d", i), 64'(bus.wb_gnt), 64'(rr_exp[i]));
      cyc();
      check($sformatf("rr_id%0d", i), 64'(bus.rf_reg_id_w), 64'(rr_id[i]));
    end
    bus.wb_req = 3'b000;
    check("rr_data_last", bus.rf_data_in, 64'h100);
    cyc();

    // Scoreboard: issue reg 7, stall until its writeback commits
    bus.iss_valid = 1'b1; bus.iss_reg_id = 5'd7; bus.rd_id1 = 5'd7; bus.rd_id2 = 5'd0;
    #1 check("sb_stall_pre", 64'(bus.stall), 64'd0);
    cyc();
    bus.iss_valid = 1'b0;
    check("sb_busy7", 64'(bus.busy_vec), 64'h80);
    check("sb_stall1", 64'(bus.stall), 64'd1);
    cyc();
    check("sb_stall2", 64'(bus.stall), 64'd1);
    set_wb(0, 5'd7, 64'h77);
    bus.wb_req = 3'b001;
    #1 check("sb_gnt", 64'(bus.wb_gnt), 64'b001);
    cyc();
    bus.wb_req = 3'b000;
    check("sb_wr", 64'(bus.rf_wr), 64'd1);
    check("sb_stall_commit", 64'(bus.stall), 64'd1);
    cyc();
    check("sb_stall_clear", 64'(bus.stall), 64'd0);
    check("sb_busy_clear", 64'(bus.busy_vec), 64'd0);

    // Simultaneous set and clear of reg 9: set wins
    bus.iss_valid = 1'b1; bus.iss_reg_id = 5'd9;
    cyc();
    bus.iss_valid = 1'b0;
    set_wb(1, 5'd9, 64'h99);
    bus.wb_req = 3'b010;
    #1 check("sim_gnt9", 64'(bus.wb_gnt), 64'b010);
    cyc();
    bus.wb_req = 3'b000;
    bus.iss_valid = 1'b1; bus.iss_reg_id = 5'd9;
    cyc();
    bus.iss_valid = 1'b0;
    check("sim_busy9", 64'(bus.busy_vec), 64'h200);

    // Clear reg 3 while setting reg 4
    bus.iss_valid = 1'b1; bus.iss_reg_id = 5'd3;
    cyc();
    bus.iss_valid = 1'b0;
    set_wb(2, 5'd3, 64'h33);
    bus.wb_req = 3'b100;
    #1 check("sim_gnt3", 64'(bus.wb_gnt), 64'b100);
    cyc();
    bus.wb_req = 3'b000;
    bus.iss_valid = 1'b1; bus.iss_reg_id = 5'd4;
    cyc();
    bus.iss_valid = 1'b0;
    check("sim_busy34", 64'(bus.busy_vec), 64'h210);
    bus.rd_id1 = 5'd4; bus.rd_id2 = 5'd4;
    #1 check("stall_same4", 64'(bus.stall), 64'd1);
    bus.rd_id1 = 5'd3; bus.rd_id2 = 5'd3;
    #1 check("stall_same3", 64'(bus.stall), 64'd0);
    bus.rd_id1 = 5'd3; bus.rd_id2 = 5'd9;
    #1 check("stall_src2", 64'(bus.stall), 64'd1);

    // Reset mid-operation: pointer advanced to 1, then reset drops write and busy
    set_wb(0, 5'd20, 64'hDEAD);
    bus.wb_req = 3'b001;
    #1 check("mid_gnt", 64'(bus.wb_gnt), 64'b001);
    cyc();
    bus.wb_req = 3'b111;
    check("mid_wr", 64'(bus.rf_wr), 64'd1);
    rst = 1'b1;
    #1 check("mid_gnt_rst", 64'(bus.wb_gnt), 64'd0);
    cyc();
    check("mid_wr_off", 64'(bus.rf_wr), 64'd0);
    check("mid_id_zero", 64'(bus.rf_reg_id_w), 64'd0);
    check("mid_data_zero", bus.rf_data_in, 64'd0);
    check("mid_busy_zero", 64'(bus.busy_vec), 64'd0);
    rst = 1'b0;
    #1 check("mid_ptr_zero", 64'(bus.wb_gnt), 64'b001);
    bus.wb_req = 3'b110;
    #1 check("mid_gnt_skip", 64'(bus.wb_gnt), 64'b010);
    cyc();
    bus.wb_req = 3'b000;
    check("post_rst_id", 64'(bus.rf_reg_id_w), 64'd9);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
